// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Per-key synchroniser, debounce FSM and long-press timer for
//                active-low push-buttons; emits clean levels and event pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int LG_W = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        logic            r_sync1;
        logic            r_sync2;
        logic            w_ks;
        state_t          r_state;
        state_t          w_state_nxt;
        logic [DB_W-1:0] r_cnt;
        logic [DB_W-1:0] w_cnt_nxt;
        logic [LG_W-1:0] r_lcnt;
        logic [LG_W-1:0] w_lcnt_nxt;
        logic            r_long_done;
        logic            w_long_done_nxt;
        logic            r_level;
        logic            r_press;
        logic            r_release;
        logic            r_long;
        logic            w_level_nxt;
        logic            w_press_nxt;
        logic            w_release_nxt;
        logic            w_long_nxt;

        // Synchroniser resets to the released level so reset exit is silent.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b1;
                r_sync2 <= 1'b1;
            end else begin
                r_sync1 <= key_in[k];
                r_sync2 <= r_sync1;
            end
        end

        assign w_ks = ~r_sync2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_lcnt      <= '0;
                r_long_done <= 1'b0;
                r_level     <= 1'b0;
                r_press     <= 1'b0;
                r_release   <= 1'b0;
                r_long      <= 1'b0;
            end else begin
                r_state     <= w_state_nxt;
                r_cnt       <= w_cnt_nxt;
                r_lcnt      <= w_lcnt_nxt;
                r_long_done <= w_long_done_nxt;
                r_level     <= w_level_nxt;
                r_press     <= w_press_nxt;
                r_release   <= w_release_nxt;
                r_long      <= w_long_nxt;
            end
        end

        always_comb begin
            w_state_nxt     = r_state;
            w_cnt_nxt       = r_cnt;
            w_lcnt_nxt      = r_lcnt;
            w_long_done_nxt = r_long_done;
            w_press_nxt     = 1'b0;
            w_release_nxt   = 1'b0;
            w_long_nxt      = 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_ks) begin
                        w_state_nxt = PRESS_WAIT;
                        w_cnt_nxt   = DB_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!w_ks) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DB_LAST) begin
                        w_state_nxt     = PRESSED;
                        w_press_nxt     = 1'b1;
                        w_lcnt_nxt      = '0;
                        w_long_done_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + DB_W'(1);
                    end
                end
                PRESSED: begin
                    if (!w_ks) begin
                        w_state_nxt = RELEASE_WAIT;
                        w_cnt_nxt   = DB_W'(1);
                    end else if (!r_long_done) begin
                        // Counter parks at its terminal value: one long pulse per press.
                        if (r_lcnt == LG_LAST) begin
                            w_long_nxt      = 1'b1;
                            w_long_done_nxt = 1'b1;
                        end else begin
                            w_lcnt_nxt = r_lcnt + LG_W'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (w_ks) begin
                        w_state_nxt = PRESSED;
                    end else if (r_cnt == DB_LAST) begin
                        w_state_nxt   = IDLE;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + DB_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
            w_level_nxt = (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
        end

        assign key_level[k]   = r_level;
        assign key_press[k]   = r_press;
        assign key_release[k] = r_release;
        assign key_long[k]    = r_long;
    end

endmodule
`default_nettype wire
